// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction type codes, J-type functions, field positions,
// register names and the fetch-stage state encoding.
package isa_pkg;

    typedef enum logic [1:0] {
        TYPE_R = 2'b00,
        TYPE_I = 2'b01,
        TYPE_J = 2'b10,
        TYPE_S = 2'b11
    } inst_type_t;

    localparam logic [4:0] FN_JMP  = 5'd0;
    localparam logic [4:0] FN_CALL = 5'd1;
    localparam logic [4:0] FN_RET  = 5'd2;

    localparam int FUNC_MSB  = 31;
    localparam int FUNC_LSB  = 27;
    localparam int IMM_MSB   = 26;
    localparam int IMM_LSB   = 3;
    localparam int TYPE_MSB  = 2;
    localparam int TYPE_LSB  = 1;
    localparam int STOP_BIT  = 0;
    localparam int IMM_WIDTH = IMM_MSB - IMM_LSB + 1;

    typedef enum logic [4:0] {
        R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
        R8,  R9,  R10, R11, R12, R13, R14, R15,
        R16, R17, R18, R19, R20, R21, R22, R23,
        R24, R25, R26, R27, R28, R29, R30, R31
    } reg_name_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Control, memory and IF/ID signals of the fetch stage; master is the fetch stage,
// slave is its environment (hazard unit, execute, instruction memory, decode).
interface instruction_fetch_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    import isa_pkg::*;

    logic                  stall;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [31:0]           instruction;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           if_id_instruction;
    logic [ADDR_WIDTH-1:0] if_id_pc;
    logic                  if_id_valid;
    logic                  halted;
    logic                  stack_error;

    modport master (
        input  stall, redirect_valid, redirect_target, instruction,
        output address, if_id_instruction, if_id_pc, if_id_valid, halted, stack_error
    );

    modport slave (
        output stall, redirect_valid, redirect_target, instruction,
        input  address, if_id_instruction, if_id_pc, if_id_valid, halted, stack_error
    );

endinterface

// File: rtl/return_address_stack.sv
// Return-address stack: push writes at sp, pop decrements sp, top is the last pushed entry.
// Overflowing pushes and underflowing pops are ignored; the caller flags them.
module return_address_stack
    import isa_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_dec;

    assign full   = (sp == PTR_W'(DEPTH));
    assign empty  = (sp == '0);
    assign sp_dec = sp - PTR_W'(1);
    assign top    = mem[IDX_W'(sp_dec)];

    always_ff @(posedge clock) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PTR_W'(1);
        end else if (pop && !empty) begin
            sp <= sp_dec;
        end
    end

    // NOTE: the storage array has no reset; only sp decides which entries are live.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[IDX_W'(sp)] <= data;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, resolves JMP/CALL/RET in fetch, honours the Stop bit
// and registers non-control-flow words into the IF/ID register.
module instruction_fetch_stage
    import isa_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    STACK_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    instruction_fetch_stage_if.master  bus
);
    fetch_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next, pc_plus_one, jump_target, offset;
    logic [31:0]           ifid_instr, ifid_instr_next;
    logic [ADDR_WIDTH-1:0] ifid_pc, ifid_pc_next;
    logic                  ifid_valid, ifid_valid_next;
    logic                  error_q, error_next;
    logic                  push, pop;
    logic                  stack_full, stack_empty;
    logic [ADDR_WIDTH-1:0] stack_top;

    inst_type_t            itype;
    logic [4:0]            func;
    logic [IMM_WIDTH-1:0]  imm;
    logic                  stop;

    assign itype = inst_type_t'(bus.instruction[TYPE_MSB:TYPE_LSB]);
    assign func  = bus.instruction[FUNC_MSB:FUNC_LSB];
    assign imm   = bus.instruction[IMM_MSB:IMM_LSB];
    assign stop  = bus.instruction[STOP_BIT];

    // Jumps are relative to the jump's own PC; wrap-around is silent.
    assign offset      = {{(ADDR_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    assign jump_target = pc + offset;
    assign pc_plus_one = pc + ADDR_WIDTH'(1);

    return_address_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_ras (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .data  (pc_plus_one),
        .top   (stack_top),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        ifid_instr_next = ifid_instr;
        ifid_pc_next    = ifid_pc;
        ifid_valid_next = ifid_valid;
        error_next      = error_q;
        push            = 1'b0;
        pop             = 1'b0;
        case (state)
            HALT: ifid_valid_next = 1'b0;
            default: begin
                if (bus.redirect_valid) begin
                    pc_next         = bus.redirect_target;
                    ifid_valid_next = 1'b0;
                end else if (!bus.stall) begin
                    if (itype == TYPE_J) begin
                        ifid_valid_next = 1'b0;
                        pc_next         = pc_plus_one;
                        case (func)
                            FN_JMP: pc_next = jump_target;
                            FN_CALL: begin
                                pc_next = jump_target;
                                push    = !stack_full;
                                if (stack_full) error_next = 1'b1;
                            end
                            FN_RET: begin
                                if (stack_empty) begin
                                    error_next = 1'b1;
                                end else begin
                                    pop     = 1'b1;
                                    pc_next = stack_top;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        ifid_instr_next = bus.instruction;
                        ifid_pc_next    = pc;
                        ifid_valid_next = 1'b1;
                        pc_next         = pc_plus_one;
                    end
                    if (stop) state_next = HALT;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RUN;
            pc         <= RESET_PC;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            ifid_instr <= ifid_instr_next;
            ifid_pc    <= ifid_pc_next;
            ifid_valid <= ifid_valid_next;
            error_q    <= error_next;
        end
    end

    assign bus.address           = pc;
    assign bus.if_id_instruction = ifid_instr;
    assign bus.if_id_pc          = ifid_pc;
    assign bus.if_id_valid       = ifid_valid;
    assign bus.halted            = (state == HALT);
    assign bus.stack_error       = error_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed and randomized bench for instruction_fetch_stage against a behavioural
// model built from a PC value, a return-address queue and a halt flag.
module tb_instruction_fetch_stage;
    import isa_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] imem [256];

    logic [31:0] m_pc, m_ii, m_ipc;
    logic        m_iv, m_halt, m_err;
    logic [31:0] m_stack [$];

    instruction_fetch_stage_if #(.ADDR_WIDTH(32)) bus ();

    instruction_fetch_stage #(
        .ADDR_WIDTH  (32),
        .STACK_DEPTH (8),
        .RESET_PC    (32'd0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always_comb bus.instruction = imem[bus.address[7:0]];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] j_word(input logic [4:0] fn, input int imm, input logic stop);
        logic [31:0] v;
        v = imm;
        return {fn, v[23:0], 2'b10, stop};
    endfunction

    function automatic logic [31:0] addi_word(input reg_name_t rd, input reg_name_t rs, input int imm);
        logic [31:0] v;
        v = imm;
        return {5'd4, rd, rs, v[13:0], 2'b01, 1'b0};
    endfunction

    function automatic logic [31:0] add_word(input reg_name_t rd, input reg_name_t rs1, input reg_name_t rs2);
        return {5'd0, rd, rs1, rs2, 9'd0, 2'b00, 1'b0};
    endfunction

    // Expected architectural effect of the coming clock edge under the current inputs.
    task automatic model_edge();
        logic [31:0] ins;
        if (reset) begin
            m_pc = 0; m_ii = 0; m_ipc = 0; m_iv = 0; m_halt = 0; m_err = 0;
            m_stack.delete();
        end else if (m_halt) begin
            m_iv = 0;
        end else if (bus.redirect_valid) begin
            m_pc = bus.redirect_target;
            m_iv = 0;
        end else if (!bus.stall) begin
            ins = imem[m_pc[7:0]];
            if (ins[2:1] == 2'b10) begin
                m_iv = 0;
                if (ins[31:27] == 5'd0) begin
                    m_pc = m_pc + 32'(signed'(ins[26:3]));
                end else if (ins[31:27] == 5'd1) begin
                    if (m_stack.size() < 8) m_stack.push_back(m_pc + 1);
                    else m_err = 1;
                    m_pc = m_pc + 32'(signed'(ins[26:3]));
                end else if (ins[31:27] == 5'd2) begin
                    if (m_stack.size() == 0) begin
                        m_err = 1;
                        m_pc  = m_pc + 1;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
                end else begin
                    m_pc = m_pc + 1;
                end
            end else begin
                m_ii  = ins;
                m_ipc = m_pc;
                m_iv  = 1;
                m_pc  = m_pc + 1;
            end
            if (ins[0]) m_halt = 1;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clock);
        #1;
        check("address", bus.address, m_pc);
        check("if_id_valid", 32'(bus.if_id_valid), 32'(m_iv));
        check("if_id_instruction", bus.if_id_instruction, m_ii);
        check("if_id_pc", bus.if_id_pc, m_ipc);
        check("halted", 32'(bus.halted), 32'(m_halt));
        check("stack_error", 32'(bus.stack_error), 32'(m_err));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        int          typ;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;

        // Sequential fetch of three ALU words.
        clear_mem();
        imem[0] = addi_word(R1, R0, 3);
        imem[1] = addi_word(R2, R0, 5);
        imem[2] = add_word(R3, R1, R2);
        do_reset();
        check("rst_address", bus.address, 32'd0);
        check("rst_valid", 32'(bus.if_id_valid), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        cycle();
        check("seq_addr1", bus.address, 32'd1);
        check("seq_pc0", bus.if_id_pc, 32'd0);
        check("seq_word0", bus.if_id_instruction, addi_word(R1, R0, 3));
        check("seq_valid0", 32'(bus.if_id_valid), 32'd1);
        cycle();
        check("seq_addr2", bus.address, 32'd2);
        check("seq_pc1", bus.if_id_pc, 32'd1);

        // JMP forward then backward.
        clear_mem();
        imem[2] = j_word(FN_JMP, 4, 1'b0);
        imem[6] = j_word(FN_JMP, -2, 1'b0);
        do_reset();
        cycles(2);
        cycle();
        check("jmp_fwd_addr", bus.address, 32'd6);
        check("jmp_fwd_valid", 32'(bus.if_id_valid), 32'd0);
        cycle();
        check("jmp_back_addr", bus.address, 32'd4);
        cycle();
        check("after_jmp_pc", bus.if_id_pc, 32'd4);

        // CALL then RET.
        clear_mem();
        imem[3]  = j_word(FN_CALL, 10, 1'b0);
        imem[13] = j_word(FN_RET, 0, 1'b0);
        do_reset();
        cycles(3);
        cycle();
        check("call_addr", bus.address, 32'd13);
        cycle();
        check("ret_addr", bus.address, 32'd4);
        check("ret_no_error", 32'(bus.stack_error), 32'd0);

        // Nine nested CALLs overflow the 8-entry stack, then unwind past empty.
        clear_mem();
        for (int k = 0; k < 9; k++) begin
            imem[2*k]   = j_word(FN_CALL, 2, 1'b0);
            imem[2*k+1] = j_word(FN_RET, 0, 1'b0);
        end
        imem[18] = j_word(FN_RET, 0, 1'b0);
        do_reset();
        cycles(8);
        check("eight_calls_ok", 32'(bus.stack_error), 32'd0);
        cycle();
        check("ninth_call_err", 32'(bus.stack_error), 32'd1);
        check("ninth_call_addr", bus.address, 32'd18);
        cycles(9);
        check("ret_empty_addr", bus.address, 32'd2);
        check("ret_empty_err", 32'(bus.stack_error), 32'd1);

        // Stall holds everything, even over a J-type; redirect overrides stall.
        clear_mem();
        imem[5] = j_word(FN_JMP, 20, 1'b0);
        do_reset();
        cycles(5);
        bus.stall = 1'b1;
        cycles(3);
        check("stall_addr", bus.address, 32'd5);
        check("stall_ifid_pc", bus.if_id_pc, 32'd4);
        check("stall_valid", 32'(bus.if_id_valid), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'd40;
        cycle();
        check("redir_addr", bus.address, 32'd40);
        check("redir_valid", 32'(bus.if_id_valid), 32'd0);
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;

        // Stop bit halts; redirect ignored; reset restarts.
        clear_mem();
        imem[7] = addi_word(R4, R4, 1) | 32'h1;
        do_reset();
        cycles(7);
        cycle();
        check("stop_ifid_pc", bus.if_id_pc, 32'd7);
        check("stop_valid", 32'(bus.if_id_valid), 32'd1);
        check("stop_halted", 32'(bus.halted), 32'd1);
        check("stop_addr", bus.address, 32'd8);
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'd40;
        cycle();
        check("halt_ignore_redir", bus.address, 32'd8);
        check("halt_valid", 32'(bus.if_id_valid), 32'd0);
        do_reset();
        check("unhalt_addr", bus.address, 32'd0);
        check("unhalt_halted", 32'(bus.halted), 32'd0);

        // PC wrap from all-ones to zero.
        clear_mem();
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFF;
        cycle();
        bus.redirect_valid = 1'b0;
        cycle();
        check("wrap_addr", bus.address, 32'd0);
        check("wrap_ifid_pc", bus.if_id_pc, 32'hFFFF_FFFF);

        // Reset in the middle of a CALL chain empties the stack.
        clear_mem();
        for (int k = 0; k < 3; k++) imem[k] = j_word(FN_CALL, 1, 1'b0);
        do_reset();
        cycles(3);
        do_reset();
        check("midrst_addr", bus.address, 32'd0);
        check("midrst_err", 32'(bus.stack_error), 32'd0);
        check("midrst_ifid_instr", bus.if_id_instruction, 32'd0);
        imem[0] = j_word(FN_RET, 0, 1'b0);
        cycle();
        check("midrst_ret_err", 32'(bus.stack_error), 32'd1);
        check("midrst_ret_addr", bus.address, 32'd1);

        // Randomized program and control inputs.
        for (int i = 0; i < 256; i++) begin
            typ = int'($urandom_range(0, 3));
            if (typ == 2) begin
                w = j_word(5'($urandom_range(0, 2)), int'($urandom_range(0, 16)) - 8,
                           ($urandom_range(0, 47) == 0));
            end else begin
                w = $urandom;
                w[2:1] = 2'(typ);
                w[0] = ($urandom_range(0, 47) == 0);
            end
            imem[i] = w;
        end
        do_reset();
        for (int n = 0; n < 800; n++) begin
            reset = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.redirect_valid = ($urandom_range(0, 9) == 0);
            bus.redirect_target = 32'($urandom_range(0, 255));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Fetch stage directly upstream of the instruction memory.
- Owns the PC, drives the memory address bus, and takes the combinational instruction word returned in the same cycle.
- Resolves J-type control flow (JMP/CALL/RET) early, keeps a small return-address stack, and honours the Stop bit.
- Registers the result into the IF/ID pipeline register consumed by decode.

Parameters:
ADDR_WIDTH, 32, PC and address bus width; word-addressed (PC+1 = next instruction)
STACK_DEPTH, 8, return-address stack entries
RESET_PC, 0, PC value after reset

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard stall from decode; hold PC, IF/ID and stack
redirect_valid  input  1  taken branch/redirect from execute
redirect_target  input  ADDR_WIDTH  new PC when redirect_valid
instruction  input  32  word read from instruction memory at address (same cycle)
address  output  ADDR_WIDTH  memory address, equals current PC
if_id_instruction  output  32  registered instruction for decode
if_id_pc  output  ADDR_WIDTH  PC of if_id_instruction
if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
halted  output  1  stage stopped after a Stop-bit instruction
stack_error  output  1  sticky: CALL on full stack or RET on empty stack

Behaviour:
- Field slicing:
  - Function [31:27]
  - J imm24 [26:3], sign-extended to ADDR_WIDTH
  - Type [2:1]
  - Stop [0]
- State machine has two states, RUN and HALT.
- Reset (synchronous, takes effect at the next edge, including mid-operation):
  - pc = RESET_PC, state = RUN
  - if_id_instruction = 0, if_id_pc = 0, if_id_valid = 0
  - stack pointer sp = 0
  - halted = 0, stack_error = 0
- address = pc, combinationally. The instruction is sampled the same cycle, so fetch latency is 1 cycle to IF/ID.
- RUN with stall=0 and redirect_valid=0, each edge:
  - Non-J instruction: IF/ID <= {instruction, pc}, valid = 1, pc <= pc+1.
  - JMP (Type=J, Function=JMP): pc <= pc + sext(imm24), relative to the jump's own PC. IF/ID valid <= 0; J-type is consumed in fetch.
  - CALL: push pc+1, then pc <= pc + sext(imm24), valid <= 0.
    - If sp == STACK_DEPTH: push dropped, stack_error <= 1, jump still taken.
  - RET: pop into pc, valid <= 0.
    - If sp == 0: stack_error <= 1, pc <= pc+1.
  - Stop bit = 1 (any type):
    - The instruction is processed as above (non-J is passed with valid = 1).
    - state <= HALT, halted <= 1.
    - pc <= the value it would otherwise take.
- HALT:
  - pc holds, if_id_valid <= 0, stack frozen.
  - stall and redirect are ignored.
  - Only reset exits HALT.
- stall=1 (RUN, no redirect):
  - pc, IF/ID, sp and state hold.
  - The J-type at pc is not acted on; the Stop bit is not acted on.
- redirect_valid=1 (RUN) has top priority, over stall, J-type decode and Stop bit:
  - pc <= redirect_target.
  - if_id_valid <= 0 (flush).
  - No push/pop, no halt.
- PC arithmetic is modulo 2^ADDR_WIDTH; wrap from all-ones to 0 is silent.
- stack_error is sticky until reset.

Decomposition:
- Shared package isa_pkg holds:
  - Type codes: R=2'b00, I=2'b01, J=2'b10, S=2'b11
  - J-type function codes: JMP=5'd0, CALL=5'd1, RET=5'd2
  - Field bit positions
  - Register names R0..R31
- The same package is used by instruction memory init and decode.
- One natural sub-module: return_address_stack.
  - Inputs: push, pop, data.
  - Outputs: top, full, empty.
  - Synchronous active-high reset.
  - Simultaneous push+pop is never issued by the fetch stage.

Test Plan:
- Reset, memory holds ADDI R1,R0,3 / ADDI R2,R0,5 / ADD R3,R1,R2 at 0..2 -> address 0,1,2 on consecutive cycles. IF/ID shows each word with pc 0,1,2 one cycle later; valid=1 from the second edge.
- JMP imm24=+4 at pc 2 -> next address 6, IF/ID valid=0 for that slot. JMP imm24=-2 at pc 6 -> address 4.
- CALL +10 at pc 3, then RET at pc 13 -> address 13, then 4. Nine nested CALLs with STACK_DEPTH=8 -> stack_error=1 on the ninth; RET on empty -> pc+1, stack_error stays 1.
- stall=1 for 3 cycles while pc=5 -> address holds 5, IF/ID unchanged. redirect_valid=1, target=40 during stall -> address 40 next cycle, valid=0.
- Stop bit set on instruction at pc 7 -> IF/ID valid=1 with pc 7, halted=1. Afterwards address frozen at 8, valid=0; redirect ignored. Reset -> address 0, halted=0.
- Reset asserted mid-CALL sequence (sp=3) -> sp=0, outputs at reset values. Then RET -> stack_error=1.
